// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the configurable UART transmitter.
//               Holds the transmitter state encoding, the parity-mode constants
//               and a frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } uart_state_e;

  // Parity-mode selector values
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Serial bits per frame: start + payload + optional parity + stop bits
  function automatic int frame_len(input int data_bits, input int parity,
                                   input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period down-counter. Reloads to CLK_DIV-1 on restart and at
//               every bit boundary; bit_done pulses for the last cycle of each
//               bit period while enabled.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               restart       - load a fresh bit period (new frame)
//               enable        - count while a frame is being shifted out
//               bit_done      - one-cycle pulse ending the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic bit_done
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (enable) begin
      // Reaching zero closes the bit; reload immediately for the next one
      cnt_d = (cnt_q == '0) ? RELOAD : (cnt_q - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = enable && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter with optional parity, one or two
//               stop bits and a line-break state. tx is registered.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               data, valid   - payload and request (captured on valid&&ready)
//               ready         - a frame can be accepted this cycle
//               brk           - line-break request (honoured only from idle)
//               tx            - serial line, idle high
//               busy          - frame or break in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  input  logic                 brk,
  output logic                 tx,
  output logic                 busy
);

  localparam int FRAME_BITS = frame_len(DATA_BITS, PARITY, STOP_BITS);

  // ---------------------------------------------------------------- checks
  if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
    $fatal(1, "uart_tx_cfg: CLK_DIV=%0d outside 1..65535", CLK_DIV);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_cfg: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_cfg: PARITY=%0d is not 0, 1 or 2", PARITY);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_cfg: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
  end
  if (FRAME_BITS > 13) begin : g_bad_frame
    $fatal(1, "uart_tx_cfg: frame of %0d bits is too long", FRAME_BITS);
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  // ---------------------------------------------------------------- state
  uart_state_e            state_q, state_d;
  logic                   tx_q, tx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   init_q;     // low until the first edge after reset
  logic                   timer_restart;
  logic                   timer_en;
  logic                   bit_done;
  logic                   handshake;

  assign ready     = init_q && (state_q == ST_IDLE) && !brk;
  assign handshake = valid && ready;
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;
  assign timer_en  = (state_q != ST_IDLE) && (state_q != ST_BREAK);

  uart_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (timer_restart),
    .enable   (timer_en),
    .bit_done (bit_done)
  );

  // tx_d is the line level for the cycle after this edge, so every bit
  // appears on the registered output exactly when its state is entered.
  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    shift_d       = shift_q;
    par_d         = par_q;
    bit_cnt_d     = bit_cnt_q;
    timer_restart = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (brk && init_q) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
        end else if (handshake) begin
          state_d       = ST_START;
          tx_d          = 1'b0;
          shift_d       = data;
          par_d         = (^data) ^ PAR_INV;
          bit_cnt_d     = '0;
          timer_restart = 1'b1;
        end
      end

      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PAR;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[DATA_BITS-1:1]};
          end
        end
      end

      ST_PAR: begin
        if (bit_done) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_BREAK: begin
        tx_d = 1'b0;
        if (!brk) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '1;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      init_q    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. Five instances cover the
//               parameter variants; a vector table drives frames and a queue
//               of per-cycle expected line levels is compared by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  localparam int NI = 5;

  typedef struct packed {
    logic tx;
    logic rdy;
    logic bsy;
  } exp_t;

  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [12:0] bits;   // frame, bit 0 = start bit
    int          flen;
    bit          b2b;    // hand-shake on the first ready cycle of the previous frame
  } vec_t;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          brk;
  logic [8:0]    data_b;
  int            sel;
  logic [NI-1:0] valid_v;
  logic [NI-1:0] tx_v;
  logic [NI-1:0] ready_v;
  logic [NI-1:0] busy_v;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   div_tab[NI] = '{4, 4, 4, 4, 1};

  for (genvar gi = 0; gi < NI; gi++) begin : g_valid
    assign valid_v[gi] = valid && (sel == gi);
  end

  // 0: 8N1      1: 8E2      2: 8O1      3: 5N1      4: 8N1 at one cycle per bit
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .data(data_b[7:0]), .valid(valid_v[0]), .ready(ready_v[0]),
    .brk(brk), .tx(tx_v[0]), .busy(busy_v[0]));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .data(data_b[7:0]), .valid(valid_v[1]), .ready(ready_v[1]),
    .brk(brk), .tx(tx_v[1]), .busy(busy_v[1]));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .data(data_b[7:0]), .valid(valid_v[2]), .ready(ready_v[2]),
    .brk(brk), .tx(tx_v[2]), .busy(busy_v[2]));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .clk(clk), .rst(rst), .data(data_b[4:0]), .valid(valid_v[3]), .ready(ready_v[3]),
    .brk(brk), .tx(tx_v[3]), .busy(busy_v[3]));
  uart_tx_cfg #(.CLK_DIV(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut4 (
    .clk(clk), .rst(rst), .data(data_b[7:0]), .valid(valid_v[4]), .ready(ready_v[4]),
    .brk(brk), .tx(tx_v[4]), .busy(busy_v[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle line monitor: one queue entry per clock cycle of a frame
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mon_tx",    {31'd0, tx_v[sel]},    {31'd0, e.tx});
      chk("mon_ready", {31'd0, ready_v[sel]}, {31'd0, e.rdy & ~brk});
      chk("mon_busy",  {31'd0, busy_v[sel]},  {31'd0, e.bsy});
    end
  end

  task automatic send(input int inst, input logic [8:0] d, input logic [12:0] bits,
                      input int flen);
    @(negedge clk);
    sel    = inst;
    data_b = d;
    valid  = 1'b1;
    chk("ready_pre_hs", {31'd0, ready_v[inst]}, 32'd1);
    @(posedge clk);
    #1;
    valid  = 1'b0;
    data_b = 9'($urandom);   // later data changes must not disturb the frame
    for (int b = 0; b < flen; b++)
      for (int c = 0; c < div_tab[inst]; c++)
        exp_q.push_back('{tx: bits[b], rdy: 1'b0, bsy: 1'b1});
    exp_q.push_back('{tx: 1'b1, rdy: 1'b1, bsy: 1'b0});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   prev_cycles;

    vecs[0]  = '{0, 9'h0A5, 13'b1_10100101_0,    10, 1'b0};
    vecs[1]  = '{0, 9'h03C, 13'b1_00111100_0,    10, 1'b1};
    vecs[2]  = '{1, 9'h0A5, 13'b11_0_10100101_0, 12, 1'b0};
    vecs[3]  = '{1, 9'h001, 13'b11_1_00000001_0, 12, 1'b1};
    vecs[4]  = '{2, 9'h0A5, 13'b1_1_10100101_0,  11, 1'b0};
    vecs[5]  = '{2, 9'h000, 13'b1_1_00000000_0,  11, 1'b0};
    vecs[6]  = '{2, 9'h007, 13'b1_0_00000111_0,  11, 1'b1};
    vecs[7]  = '{3, 9'h013, 13'b1_10011_0,       7,  1'b0};
    vecs[8]  = '{3, 9'h0EC, 13'b1_01100_0,       7,  1'b1};
    vecs[9]  = '{4, 9'h0FF, 13'b1_11111111_0,    10, 1'b0};
    vecs[10] = '{4, 9'h05A, 13'b1_01011010_0,    10, 1'b1};

    rst = 1'b1; valid = 1'b0; brk = 1'b0; data_b = '0; sel = 0;
    prev_cycles = 0;

    // Reset state and release
    repeat (2) @(negedge clk);
    chk("rst_ready", {27'd0, ready_v}, 32'd0);
    chk("rst_tx",    {27'd0, tx_v},    32'h1F);
    chk("rst_busy",  {27'd0, busy_v},  32'd0);
    rst = 1'b0;
    #1;
    chk("ready_before_first_edge", {27'd0, ready_v}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_first_edge",  {27'd0, ready_v}, 32'h1F);

    // Vector table: single and back-to-back frames per configuration
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].b2b) repeat (prev_cycles) @(negedge clk);
      else             drain();
      send(vecs[i].inst, vecs[i].data, vecs[i].bits, vecs[i].flen);
      prev_cycles = vecs[i].flen * div_tab[vecs[i].inst];
    end
    drain();

    // Break while idle, then brk and valid together
    sel = 0;
    @(negedge clk);
    brk = 1'b1;
    #1;
    chk("brk_ready_now", {31'd0, ready_v[0]}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("brk_tx",    {31'd0, tx_v[0]},    32'd0);
      chk("brk_busy",  {31'd0, busy_v[0]},  32'd1);
      chk("brk_ready", {31'd0, ready_v[0]}, 32'd0);
    end
    valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("brk_valid_ready", {31'd0, ready_v[0]}, 32'd0);
      chk("brk_valid_tx",    {31'd0, tx_v[0]},    32'd0);
    end
    brk = 1'b0; valid = 1'b0;
    #1;
    chk("brk_release_ready_same", {31'd0, ready_v[0]}, 32'd0);
    @(negedge clk);
    chk("brk_exit_tx",    {31'd0, tx_v[0]},    32'd1);
    chk("brk_exit_ready", {31'd0, ready_v[0]}, 32'd1);
    chk("brk_exit_busy",  {31'd0, busy_v[0]},  32'd0);

    // Break raised mid-frame waits for the frame to finish
    send(0, 9'h0A5, 13'b1_10100101_0, 10);
    repeat (8) @(negedge clk);
    brk = 1'b1;
    drain();
    @(negedge clk);
    chk("brk_after_frame_tx",   {31'd0, tx_v[0]},   32'd0);
    chk("brk_after_frame_busy", {31'd0, busy_v[0]}, 32'd1);
    brk = 1'b0;
    @(negedge clk);
    chk("brk_after_frame_exit", {31'd0, tx_v[0]}, 32'd1);

    // Reset during a data bit aborts the frame at once
    drain();
    send(0, 9'h0F0, 13'b1_11110000_0, 10);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_tx",    {27'd0, tx_v},    32'h1F);
    chk("midrst_busy",  {27'd0, busy_v},  32'd0);
    chk("midrst_ready", {27'd0, ready_v}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_back", {31'd0, ready_v[0]}, 32'd1);
    chk("midrst_idle_tx",    {31'd0, tx_v[0]},    32'd1);
    send(0, 9'h0C3, 13'b1_11000011_0, 10);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 8, giving clk cycles per serial bit (legal range 1..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the payload length (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting the parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal values 1 or 2).
REQ-005 The block SHALL have input clk, 1 bit: the single clock, all logic rising-edge.
REQ-006 The block SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have input data, DATA_BITS bits: the payload, sampled on handshake.
REQ-008 The block SHALL have input valid, 1 bit: the payload request.
REQ-009 The block SHALL have output ready, 1 bit: the block can accept a frame this cycle.
REQ-010 The block SHALL have input brk, 1 bit: line-break request.
REQ-011 The block SHALL have output tx, 1 bit: the serial line, idle high.
REQ-012 The block SHALL have output busy, 1 bit: a frame or break is in progress.

Function
REQ-013 The block SHALL treat a handshake as valid && ready at a rising edge; data SHALL be captured only then, and later changes to data SHALL NOT affect the frame.
REQ-014 The frame SHALL be sent in this order: start bit (0), data LSB first, parity bit if PARITY != 0, then STOP_BITS stop bits (1); the frame length F = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
REQ-015 Parity SHALL be computed as follows: even mode gives the XOR of all data bits; odd mode gives its inverse.
REQ-016 The state machine SHALL have states IDLE, START, DATA, PAR, STOP, BREAK; ready SHALL be 1 only in IDLE with brk = 0.
REQ-017 Transitions SHALL be:
  - IDLE to START on handshake.
  - START to DATA.
  - DATA to PAR or STOP after DATA_BITS bits (PAR only if PARITY != 0).
  - PAR to STOP.
  - STOP to IDLE after STOP_BITS bits.
  - IDLE to BREAK when brk = 1.
  - BREAK to IDLE when brk = 0.
REQ-018 If the handshake occurs at edge k, tx SHALL be 0 for cycles k+1 .. k+CLK_DIV, each later bit SHALL occupy exactly CLK_DIV cycles, and ready SHALL reassert at cycle k+F*CLK_DIV+1.
REQ-019 Back-to-back frames SHALL be supported: a handshake on the first ready cycle SHALL start the next start bit on the following cycle, with no extra idle bit.
REQ-020 In IDLE tx SHALL be 1; in BREAK tx SHALL be 0; busy SHALL equal NOT IDLE.
REQ-021 If brk and valid are both high in IDLE, brk SHALL win, with no handshake because ready = 0.
REQ-022 brk asserted mid-frame SHALL be ignored until the frame ends and IDLE is reached.
REQ-023 In the BREAK state, brk deasserting SHALL return tx to 1 on the next cycle, with ready = 1 in that same cycle.
REQ-024 The bit-period counter SHALL be at least clog2(CLK_DIV) bits wide and SHALL reload to CLK_DIV-1 at each bit boundary; CLK_DIV = 1 SHALL give one bit per cycle.
REQ-025 tx SHALL be driven from a register, so it is glitch-free.

Reset
REQ-026 rst SHALL, asynchronously, force state IDLE, tx = 1, busy = 0, the counters to 0, and the shift register to all ones.
REQ-027 ready SHALL be 0 while rst = 1 and SHALL become 1 on the first edge after release, if brk = 0.
REQ-028 rst mid-frame SHALL abort the frame immediately, with tx = 1 in the same cycle, and no partial frame SHALL resume.

Structure
REQ-029 A package uart_pkg SHALL hold the state enum, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), and a frame-length function of the parameters.
REQ-030 One sub-module, uart_bit_timer, SHALL hold the CLK_DIV down-counter and produce a one-cycle bit_done pulse with a restart input.
REQ-031 The parameters SHALL be checked at elaboration, with illegal values raising a fatal error.

Verification
REQ-032 Scenario: defaults with CLK_DIV = 4, send 0xA5 -> tx equals 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; ready reasserts 41 cycles after the handshake.
REQ-033 Scenario: PARITY = 2 and then PARITY = 1, send 0xA5 -> the parity bit is 0 (even) and 1 (odd); with STOP_BITS = 2 the frame is 12 bits.
REQ-034 Scenario: DATA_BITS = 5, send 0x13 then 0x0C back-to-back -> the second start bit follows the first stop bit with zero gap, and data bits above bit 4 are ignored.
REQ-035 Scenario: assert brk for 20 cycles while idle, then raise valid and brk together -> tx stays 0 for 20 cycles; while both are high, no handshake occurs and ready = 0.
REQ-036 Scenario: assert rst during a data bit -> tx = 1 and busy = 0 immediately; the next handshake sends a complete new frame.
REQ-037 Scenario: CLK_DIV = 1, send 0xFF -> a 10-cycle frame of 0 followed by nine 1s, and ready reasserts at k+11.
